dm_arbiter: RTL

Two-port request/acknowledge arbiter that shares the single data-memory (dm) instance between the SISC core load/store path (port 0) and a debug/DMA loader (port 1). It serialises accesses and drives dm read/write addresses and data. It generates the dm_we high-then-low pulse whose falling edge commits a dm write. It also captures dm read data into the granted requester's return register.

---
 rtl/dm_arb_pkg.sv | 17 +
 rtl/dm_arb_pick.sv | 30 +++
 rtl/dm_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dm_arb_pkg.sv
// Shared constants for the data-memory arbiter: FSM encoding, default widths,
// the highest implemented dm word address and the requester port ids.
package dm_arb_pkg;

  localparam int ADDR_W_DEF   = 16;
  localparam int DATA_W_DEF   = 32;
  localparam int MAX_ADDR_DEF = 65532;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RD    = 2'd1;
  localparam logic [1:0] ST_WR_HI = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational winner select between the core (port 0) and debug loader (port 1).
// DM_ARB_RR_EN selects round-robin on ties; otherwise port 0 has strict priority.
module dm_arb_pick
  import dm_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
`ifdef DM_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic gnt_vld,
  output logic gnt_id
);

  always_comb begin
    gnt_vld = req0 | req1;
    gnt_id  = PORT_CPU;
`ifdef DM_ARB_RR_EN
    // On a tie the port that was not served last time goes next.
    if (req0 && req1)
      gnt_id = ~last_grant;
    else if (req1)
      gnt_id = PORT_DBG;
`else
    if (!req0 && req1)
      gnt_id = PORT_DBG;
`endif
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port request/acknowledge arbiter sharing one data memory between the core
// and the debug/DMA loader. Optional round-robin arbitration via DM_ARB_RR_EN.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_ADDR = MAX_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] dm_read_addr,
  output logic [ADDR_W-1:0] dm_write_addr,
  output logic [DATA_W-1:0] dm_write_data,
  output logic              dm_we,
  input  logic [DATA_W-1:0] dm_read_data,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_ADDR);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              cur_port;
  logic              gnt_vld;
  logic              gnt_id;
  logic              sel_we;
  logic              sel_bad;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef DM_ARB_RR_EN
  logic last_grant;
`endif

  dm_arb_pick u_pick (
    .req0       (req0),
    .req1       (req1),
`ifdef DM_ARB_RR_EN
    .last_grant (last_grant),
`endif
    .gnt_vld    (gnt_vld),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    sel_we    = (gnt_id == PORT_DBG) ? we1    : we0;
    sel_addr  = (gnt_id == PORT_DBG) ? addr1  : addr0;
    sel_wdata = (gnt_id == PORT_DBG) ? wdata1 : wdata0;
    sel_bad   = (sel_addr > MAX_A);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (gnt_vld) begin
          if (sel_bad)
            state_nxt = ST_DONE;
          else if (sel_we)
            state_nxt = ST_WR_HI;
          else
            state_nxt = ST_RD;
        end
      end
      ST_RD, ST_WR_HI: state_nxt = ST_DONE;
      default:         state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      cur_port      <= PORT_CPU;
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      err0          <= 1'b0;
      err1          <= 1'b0;
      rdata0        <= '0;
      rdata1        <= '0;
      dm_read_addr  <= '0;
      dm_write_addr <= '0;
      dm_write_data <= '0;
      dm_we         <= 1'b0;
`ifdef DM_ARB_RR_EN
      last_grant    <= PORT_DBG;
`endif
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE);
      // ack/err are one-cycle strobes: only set on the edge entering DONE.
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            cur_port <= gnt_id;
`ifdef DM_ARB_RR_EN
            last_grant <= gnt_id;
`endif
            if (sel_bad) begin
              // Out-of-range: dm untouched, answer straight away with err.
              ack0 <= (gnt_id == PORT_CPU);
              ack1 <= (gnt_id == PORT_DBG);
              err0 <= (gnt_id == PORT_CPU);
              err1 <= (gnt_id == PORT_DBG);
            end else if (sel_we) begin
              dm_write_addr <= sel_addr;
              dm_write_data <= sel_wdata;
              dm_we         <= 1'b1;
            end else begin
              dm_read_addr <= sel_addr;
            end
          end
        end
        ST_RD: begin
          if (cur_port == PORT_DBG)
            rdata1 <= dm_read_data;
          else
            rdata0 <= dm_read_data;
          ack0 <= (cur_port == PORT_CPU);
          ack1 <= (cur_port == PORT_DBG);
        end
        ST_WR_HI: begin
          // Falling dm_we at this edge commits the write in dm.
          dm_we <= 1'b0;
          ack0  <= (cur_port == PORT_CPU);
          ack1  <= (cur_port == PORT_DBG);
        end
        default: ;
      endcase
    end
  end

endmodule
